// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer sharing one memory port between fetch and load/store.
// Optional performance counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_less,
    input  logic        br_equal,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_wren,
    output logic        ir_wren,
    output logic        mdr_wren,
    output logic        pc_wren,
    output logic        pc_sel,
    output logic        br_un,
    output logic        rd_wren,
    output logic        opa_sel,
    output logic        opb_sel,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_W = MEM_TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        trap_q, trap_d;
    logic [1:0]  trap_cause_q, trap_cause_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_op, is_opimm, is_load, is_store, is_branch;
    logic        is_lui, is_auipc, is_jal, is_jalr;
    logic        illegal;
    logic        br_taken;
    logic        mem_timeout;
    logic        unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        is_op     = 1'b0;
        is_opimm  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            7'b0110011: is_op     = 1'b1;
            7'b0010011: is_opimm  = 1'b1;
            7'b0000011: is_load   = 1'b1;
            7'b0100011: is_store  = 1'b1;
            7'b1100011: is_branch = 1'b1;
            7'b0110111: is_lui    = 1'b1;
            7'b0010111: is_auipc  = 1'b1;
            7'b1101111: is_jal    = 1'b1;
            7'b1100111: is_jalr   = 1'b1;
            default: ;
        endcase
    end

    assign illegal = ~(is_op | is_opimm | is_load | is_store | is_branch |
                       is_lui | is_auipc | is_jal | is_jalr) |
                     (is_branch & (funct3 == 3'b010 | funct3 == 3'b011));

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:         br_taken = br_equal;
            3'b001:         br_taken = ~br_equal;
            3'b100, 3'b110: br_taken = br_less;
            3'b101, 3'b111: br_taken = ~br_less;
            default:        br_taken = 1'b0;
        endcase
    end

    // Datapath selects follow the IR in every state; only the strobes are state-gated.
    always_comb begin
        alu_op = 4'b0000;
        if (is_op) begin
            alu_op = {instr[30], funct3};
        end else if (is_opimm) begin
            alu_op = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
        end
        opa_sel = is_auipc | is_jal | is_branch;
        opb_sel = ~is_op;
        br_un   = is_branch & instr[13];
        pc_sel  = is_branch ? br_taken : (is_jal | is_jalr);
        wb_sel  = (is_jal | is_jalr) ? 2'b10 : (is_load ? 2'b01 : 2'b00);
    end

    // An ack arriving in the deadline cycle still completes the access.
    assign mem_timeout = (wait_cnt_q == TIMEOUT_W) & ~mem_ack;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = 8'd0;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_wren     = 1'b0;
        ir_wren      = 1'b0;
        mdr_wren     = 1'b0;
        pc_wren      = 1'b0;
        rd_wren      = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_wren = 1'b1;
                    state_d = S_DECODE;
                end else if (mem_timeout) begin
                    state_d      = S_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d      = S_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load | is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_wren = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_wren     = is_store;
                if (mem_ack) begin
                    if (is_store) begin
                        pc_wren = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_wren = 1'b1;
                        state_d  = S_WB;
                    end
                end else if (mem_timeout) begin
                    state_d      = S_TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                rd_wren = 1'b1;
                pc_wren = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_FETCH;
        endcase
        // Strobes must never escape while reset is held, even mid-access.
        if (rst) begin
            mem_req  = 1'b0;
            mem_wren = 1'b0;
            ir_wren  = 1'b0;
            mdr_wren = 1'b0;
            pc_wren  = 1'b0;
            rd_wren  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= 8'd0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = (state_q != S_TRAP) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instret_cnt_d = retire ? instret_cnt_q + 32'd1 : instret_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle control expectations are built from the
// instruction's class as a list of phases, then compared against the DUT cycle by cycle.
module tb_mc_ctrl_fsm;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, br_less, br_equal, mem_ack;
    logic [31:0] instr;
    logic        mem_req, mem_addr_sel, mem_wren, ir_wren, mdr_wren, pc_wren, pc_sel;
    logic        br_un, rd_wren, opa_sel, opb_sel, retire, trap;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, trap_cause;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .br_less(br_less), .br_equal(br_equal),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
        .mem_wren(mem_wren), .ir_wren(ir_wren), .mdr_wren(mdr_wren), .pc_wren(pc_wren),
        .pc_sel(pc_sel), .br_un(br_un), .rd_wren(rd_wren), .opa_sel(opa_sel),
        .opb_sel(opb_sel), .alu_op(alu_op), .wb_sel(wb_sel), .retire(retire),
        .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Vector layout: [17] req [16] wren [15] ir [14] mdr [13] pcw [12] rd [11] retire
    // [10] addr_sel&req [9] pc_sel [8] br_un [7] opa [6] opb [5:2] alu_op [1:0] wb_sel
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    bit          ack_q[$];

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_ADDI = 32'hFFF08193;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BLTU = 32'h0020E463;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;

    function automatic logic [17:0] observe();
        return {mem_req, mem_wren, ir_wren, mdr_wren, pc_wren, rd_wren, retire,
                mem_addr_sel & mem_req, pc_sel, br_un, opa_sel, opb_sel, alu_op, wb_sel};
    endfunction

    function automatic bit ref_legal(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (op == 7'b1100011) return !(ins[14:13] == 2'b01);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic [9:0] ref_sel(input logic [31:0] ins, input bit bl, input bit be);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] alu;
        logic [1:0] wb;
        bit br, jmp, taken;
        op  = ins[6:0];
        f3  = ins[14:12];
        br  = (op == 7'b1100011);
        jmp = (op == 7'b1101111) || (op == 7'b1100111);
        // funct3 bit0 inverts the sense, bit2 picks "less" over "equal"
        taken = f3[2] ? (bl ^ f3[0]) : (be ^ f3[0]);
        alu = 4'd0;
        if (op == 7'b0110011) alu = {ins[30], f3};
        else if (op == 7'b0010011) alu = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
        wb = jmp ? 2'b10 : ((op == 7'b0000011) ? 2'b01 : 2'b00);
        return {br ? taken : jmp, br & ins[13],
                (op == 7'b0010111) || (op == 7'b1101111) || br,
                op != 7'b0110011, alu, wb};
    endfunction

    function automatic logic [17:0] vec(input bit req, input bit wr, input bit irw,
                                        input bit mdr, input bit pcw, input bit rdw,
                                        input bit ret, input bit addr, input logic [9:0] s);
        return {req, wr, irw, mdr, pcw, rdw, ret, addr, s};
    endfunction

    // Phase list: FETCH waits+ack, DECODE, then per class EXEC / MEM waits+ack / WB.
    function automatic void build_plan(input logic [31:0] ins, input int fw, input int mw,
                                       input bit bl, input bit be);
        logic [9:0] s;
        bit ld, st;
        s  = ref_sel(ins, bl, be);
        ld = (ins[6:0] == 7'b0000011);
        st = (ins[6:0] == 7'b0100011);
        exp_q.delete();
        ack_q.delete();
        for (int i = 0; i < fw; i++) begin
            ack_q.push_back(1'b0); exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, s));
        end
        ack_q.push_back(1'b1); exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, s));
        ack_q.push_back(1'($urandom_range(0, 1))); exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, s));
        if (!ref_legal(ins)) begin
            for (int i = 0; i < 3; i++) begin
                ack_q.push_back(1'($urandom_range(0, 1))); exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, s));
            end
            return;
        end
        if (ins[6:0] == 7'b1100011) begin
            ack_q.push_back(1'($urandom_range(0, 1))); exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 1, 0, s));
            return;
        end
        ack_q.push_back(1'($urandom_range(0, 1))); exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, s));
        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                ack_q.push_back(1'b0); exp_q.push_back(vec(1, st, 0, 0, 0, 0, 0, 1, s));
            end
            ack_q.push_back(1'b1); exp_q.push_back(vec(1, st, 0, ld, st, 0, st, 1, s));
            if (st) return;
        end
        ack_q.push_back(1'($urandom_range(0, 1))); exp_q.push_back(vec(0, 0, 0, 0, 1, 1, 1, 0, s));
    endfunction

    // Called at a falling edge; leaves the bench at the falling edge after the last cycle.
    task automatic run_plan(input logic [31:0] ins, input bit bl, input bit be);
        obs_q.delete();
        foreach (ack_q[k]) begin
            instr = ins; br_less = bl; br_equal = be; mem_ack = ack_q[k];
            #1;
            obs_q.push_back(observe());
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b1; instr = I_SW; br_less = 1'b0; br_equal = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if (observe() >> 10 !== 18'd0) begin
                n_fail++; $display("FAIL reset_strobes cyc%0d got=%h want=0", c, observe() >> 10);
            end
        end
        n_tests++;
        if ({trap, trap_cause} !== 3'b000) begin
            n_fail++; $display("FAIL reset_trap got=%b want=000", {trap, trap_cause});
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_add();
        build_plan(I_ADD, 0, 0, 0, 0);
        run_plan(I_ADD, 0, 0);
        foreach (exp_q[k]) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL add cyc%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
            end
        end
        n_tests++;
        if (obs_q[3][13:11] !== 3'b111 || obs_q[3][9] !== 1'b0 || obs_q[3][5:2] !== 4'b0000) begin
            n_fail++; $display("FAIL add_wb got=%h want=pcw/rd/retire=1 pc_sel=0 alu=0", obs_q[3]);
        end
        $display("[TB] ADD latency %0d cycles", obs_q.size());
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins_l[3];
        logic [3:0]  alu_l[3];
        ins_l = '{I_SUB, I_SRAI, I_ADDI};
        alu_l = '{4'b1000, 4'b1101, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            build_plan(ins_l[i], 0, 0, 0, 0);
            run_plan(ins_l[i], 0, 0);
            foreach (exp_q[k]) begin
                n_tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL alu_seq ins=%h cyc%0d got=%h want=%h", ins_l[i], k, obs_q[k], exp_q[k]);
                end
            end
            n_tests++;
            if (obs_q[2][5:2] !== alu_l[i] || obs_q[2][6] !== (i != 0)) begin
                n_fail++; $display("FAIL alu_op ins=%h got=%b opb=%b want=%b", ins_l[i], obs_q[2][5:2], obs_q[2][6], alu_l[i]);
            end
            $display("[TB] ins=%h alu_op=%b", ins_l[i], obs_q[2][5:2]);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins_l[3];
        bit          be_l[3];
        ins_l = '{I_BNE, I_BNE, I_BLTU};
        be_l  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            build_plan(ins_l[i], 0, 0, 1'b1, be_l[i]);
            run_plan(ins_l[i], 1'b1, be_l[i]);
            foreach (exp_q[k]) begin
                n_tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL branch_seq ins=%h cyc%0d got=%h want=%h", ins_l[i], k, obs_q[k], exp_q[k]);
                end
            end
            n_tests++;
            if (obs_q.size() != 3 || obs_q[2][13] !== 1'b1 || obs_q[2][9] !== !be_l[i] || obs_q[2][8] !== (i == 2)) begin
                n_fail++; $display("FAIL branch ins=%h got=%h want pcw=1 pc_sel=%b br_un=%b", ins_l[i], obs_q[2], !be_l[i], i == 2);
            end
            $display("[TB] branch ins=%h eq=%b pc_sel=%b", ins_l[i], be_l[i], obs_q[2][9]);
        end
    endtask

    task automatic test_load_wait();
        int req_mem, mdr_n;
        build_plan(I_LW, 0, 3, 0, 0);
        run_plan(I_LW, 0, 0);
        req_mem = 0; mdr_n = 0;
        foreach (exp_q[k]) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL lw_seq cyc%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
            end
            req_mem += int'(obs_q[k][10]);
            mdr_n   += int'(obs_q[k][14]);
        end
        n_tests++;
        if (req_mem != 4 || mdr_n != 1 || obs_q[7][1:0] !== 2'b01 || obs_q[7][11] !== 1'b1) begin
            n_fail++; $display("FAIL lw_wait req=%0d mdr=%0d wb=%h want req=4 mdr=1 wb_sel=01 retire@7", req_mem, mdr_n, obs_q[7]);
        end
        $display("[TB] LW with 3 wait cycles, %0d cycles", obs_q.size());
    endtask

    task automatic test_random();
        logic [6:0] opc_l[9];
        logic [2:0] bf_l[6];
        logic [31:0] ins;
        int fw, mw;
        bit bl, be;
        opc_l = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        bf_l  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int t = 0; t < 80; t++) begin
            ins = $urandom;
            ins[6:0] = opc_l[$urandom_range(0, 8)];
            if (ins[6:0] == 7'b1100011) ins[14:12] = bf_l[$urandom_range(0, 5)];
            fw = $urandom_range(0, TMO);
            mw = $urandom_range(0, TMO);
            bl = 1'($urandom_range(0, 1));
            be = 1'($urandom_range(0, 1));
            build_plan(ins, fw, mw, bl, be);
            run_plan(ins, bl, be);
            foreach (exp_q[k]) begin
                n_tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL rand t%0d ins=%h fw=%0d mw=%0d cyc%0d got=%h want=%h", t, ins, fw, mw, k, obs_q[k], exp_q[k]);
                end
            end
            n_tests++;
            if (trap !== 1'b0) begin
                n_fail++; $display("FAIL rand_trap t%0d ins=%h got=%b want=0", t, ins, trap);
            end
            $display("[TB] rand t%0d ins=%h fw=%0d mw=%0d cycles=%0d", t, ins, fw, mw, obs_q.size());
        end
    endtask

    task automatic test_timeout();
        int req_n, bad_n;
        // Fetch never acknowledged: TMO counted waits, then the deadline cycle traps.
        do_reset();
        mem_ack = 1'b0; instr = I_ADD;
        req_n = 0; bad_n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            req_n += int'(mem_req);
            bad_n += int'(mem_req & trap);
            @(negedge clk);
        end
        mem_ack = 1'b1; #1;
        n_tests++;
        if (req_n != TMO + 1 || bad_n != 0 || trap !== 1'b1 || trap_cause !== 2'b10 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_timeout req=%0d overlap=%0d trap=%b cause=%b req_now=%b want %0d/0/1/10/0",
                               req_n, bad_n, trap, trap_cause, mem_req, TMO + 1);
        end
        @(negedge clk);
        // Load address phase never acknowledged.
        do_reset();
        build_plan(I_LW, 0, 0, 0, 0);
        void'(exp_q.pop_back()); void'(ack_q.pop_back());
        void'(exp_q.pop_back()); void'(ack_q.pop_back());
        run_plan(I_LW, 0, 0);
        req_n = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ack = 1'b0; #1;
            req_n += int'(mem_req & mem_addr_sel);
            @(negedge clk);
        end
        n_tests++;
        if (req_n != TMO + 1 || trap !== 1'b1 || trap_cause !== 2'b10) begin
            n_fail++; $display("FAIL mem_timeout req=%0d trap=%b cause=%b want %0d/1/10", req_n, trap, trap_cause, TMO + 1);
        end
        do_reset();
        n_tests++;
        if ({trap, trap_cause} !== 3'b000) begin
            n_fail++; $display("FAIL trap_clear got=%b want=000", {trap, trap_cause});
        end
        // Ack in the deadline cycle completes the access.
        build_plan(I_LW, TMO, TMO, 0, 0);
        run_plan(I_LW, 0, 0);
        foreach (exp_q[k]) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL deadline_ack cyc%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
            end
        end
        n_tests++;
        if (trap !== 1'b0) begin
            n_fail++; $display("FAIL deadline_trap got=%b want=0", trap);
        end
        $display("[TB] timeout and deadline ack checked");
    endtask

    task automatic test_illegal();
        logic [31:0] ins_l[3];
        ins_l = '{32'h00000000, 32'h00002063, 32'h0000007F};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            build_plan(ins_l[i], 0, 0, 0, 0);
            run_plan(ins_l[i], 0, 0);
            foreach (exp_q[k]) begin
                n_tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL illegal_seq ins=%h cyc%0d got=%h want=%h", ins_l[i], k, obs_q[k], exp_q[k]);
                end
            end
            n_tests++;
            if (trap !== 1'b1 || trap_cause !== 2'b01) begin
                n_fail++; $display("FAIL illegal ins=%h trap=%b cause=%b want 1/01", ins_l[i], trap, trap_cause);
            end
            $display("[TB] illegal ins=%h cause=%b", ins_l[i], trap_cause);
        end
        do_reset();
    endtask

    task automatic test_rst_mid();
        build_plan(I_SW, 0, 2, 0, 0);
        void'(exp_q.pop_back()); void'(ack_q.pop_back());
        void'(exp_q.pop_back()); void'(ack_q.pop_back());
        run_plan(I_SW, 0, 0);
        rst = 1'b1; mem_ack = 1'b0; #1;
        n_tests++;
        if (mem_req !== 1'b0 || mem_wren !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid req=%b wren=%b want 0/0", mem_req, mem_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        build_plan(I_ADD, TMO, 0, 0, 0);
        run_plan(I_ADD, 0, 0);
        foreach (exp_q[k]) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL rst_restart cyc%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("[TB] reset mid-store, restart from fetch");
    endtask

`ifdef MC_CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            build_plan(I_ADD, 0, 0, 0, 0);
            run_plan(I_ADD, 0, 0);
        end
        #1;
        n_tests++;
        if (cycle_cnt !== 32'd12 || instret_cnt !== 32'd3) begin
            n_fail++; $display("FAIL perf cycle=%0d instret=%0d want 12/3", cycle_cnt, instret_cnt);
        end
        @(negedge clk);
        $display("[TB] perf cycle=%0d instret=%0d", cycle_cnt, instret_cnt);
    endtask
`endif

    initial begin
        rst = 1'b1; mem_ack = 1'b0; instr = 32'd0; br_less = 1'b0; br_equal = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_load_wait();
        test_random();
        test_timeout();
        test_illegal();
        test_rst_mid();
`ifdef MC_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
